// File: rtl/spi_dev_core_pkg.sv
// Shared constants for the SPI device byte engine.
`timescale 1ns/1ps
package spi_dev_core_pkg;
  // Default synchronizer depth for every spi_clk/cs_n -> clk crossing.
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/spi_dev_sync.sv
// N-stage synchronizer with edge detect; level, rise, fall and toggle outputs.
`timescale 1ns/1ps
module spi_dev_sync
  import spi_dev_core_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic tgl
);
  logic [STAGES-1:0] sync;
  logic              prev;

  // Shift the async input through the chain; prev holds last synced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  // Edges come from two flops, so each pulse is clean and one clk wide.
  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
  assign tgl  = q ^ prev;
endmodule

// File: rtl/spi_dev_core.sv
// SPI mode-0 device byte engine, MSB first; byte events cross into clk as toggles.
`timescale 1ns/1ps
module spi_dev_core
  import spi_dev_core_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] user_out,
  output logic       user_out_stb,
  input  logic [7:0] user_in,
  output logic       user_in_ack,
  output logic       csn_state,
  output logic       csn_rise,
  output logic       csn_fall
);
  logic       spi_rst;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr, tx_sr;
  logic [7:0] rx_hold;
  logic       rx_tgl, tx_tgl, miso_q;
  logic       rx_evt, tx_evt;
  logic       rx_q, rx_rise, rx_fall, tx_q, tx_rise, tx_fall;
  logic       cs_tgl;
  logic       unused_sync;

  // Deselect clears all per-byte state so each select starts at bit 0.
  assign spi_rst = rst | spi_cs_n;

  // Bit counter and shift registers; TX reloads from user_in on bit 0.
  always_ff @(posedge spi_clk or posedge spi_rst) begin
    if (spi_rst) begin
      bit_cnt <= 3'd0;
      rx_sr   <= 7'd0;
      tx_sr   <= 7'd0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sr   <= {rx_sr[5:0], spi_mosi};
      tx_sr   <= (bit_cnt == 3'd0) ? user_in[6:0] : {tx_sr[5:0], 1'b0};
    end
  end

  // Completion toggles and hold reg survive deselect: clearing a toggle on
  // CS rise would look like a byte event on the clk side.
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      rx_hold <= 8'd0;
      rx_tgl  <= 1'b0;
      tx_tgl  <= 1'b0;
    end else if (!spi_cs_n) begin
      if (bit_cnt == 3'd7) begin
        rx_hold <= {rx_sr, spi_mosi};
        rx_tgl  <= ~rx_tgl;
      end
      if (bit_cnt == 3'd0)
        tx_tgl <= ~tx_tgl;
    end
  end

  // MISO changes on falling edges so the host samples it stable on rising.
  always_ff @(negedge spi_clk or posedge spi_rst) begin
    if (spi_rst) miso_q <= 1'b0;
    else         miso_q <= tx_sr[6];
  end

  // Bit 7 comes straight from user_in so it is valid before the first edge.
  assign spi_miso = (bit_cnt == 3'd0) ? user_in[7] : miso_q;

  spi_dev_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rx_sync (
    .clk(clk), .rst(rst), .d(rx_tgl),
    .q(rx_q), .rise(rx_rise), .fall(rx_fall), .tgl(rx_evt)
  );

  spi_dev_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_tx_sync (
    .clk(clk), .rst(rst), .d(tx_tgl),
    .q(tx_q), .rise(tx_rise), .fall(tx_fall), .tgl(tx_evt)
  );

  spi_dev_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(spi_cs_n),
    .q(csn_state), .rise(csn_rise), .fall(csn_fall), .tgl(cs_tgl)
  );

  // Only the toggle events of the byte syncs and the level/edges of CS matter.
  assign unused_sync = &{1'b0, rx_q, rx_rise, rx_fall, tx_q, tx_rise, tx_fall, cs_tgl};

  // Register strobes one clk after CS edges so csn_fall always leads the first stb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      user_out     <= 8'd0;
      user_out_stb <= 1'b0;
      user_in_ack  <= 1'b0;
    end else begin
      user_out_stb <= rx_evt;
      user_in_ack  <= tx_evt;
      if (rx_evt) user_out <= rx_hold;
    end
  end
endmodule

// File: tb/tb_spi_dev_core.sv
// Self-checking bench for spi_dev_core: host model plus event log vs. scoreboard.
`timescale 1ns/1ps
module tb_spi_dev_core;
  localparam real CLK_H = 16.667;  // 30 MHz
  localparam real SCK_H = 6.25;    // 80 MHz
  localparam real GAP   = 120.0;

  logic       clk = 1'b0, rst = 1'b1;
  logic       spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] user_out, user_in;
  logic       user_out_stb, user_in_ack, csn_state, csn_rise, csn_fall;

  // Consumer: user_in = loaded base + one per ack.
  logic [7:0] ui_base = 8'd0, ui_acks = 8'd0;
  assign user_in = ui_base + ui_acks;

  spi_dev_core #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .user_out(user_out),
    .user_out_stb(user_out_stb), .user_in(user_in), .user_in_ack(user_in_ack),
    .csn_state(csn_state), .csn_rise(csn_rise), .csn_fall(csn_fall)
  );

  always #(CLK_H) clk = ~clk;

  // Event log written only by the monitor.
  int         n_stb = 0, n_ack = 0, n_fall = 0, n_rise = 0;
  logic       in_sel = 1'b0;
  logic [7:0] got [64];
  logic       sel_ok [64];

  // Monitor: sample outputs on the falling clk edge and log events.
  always @(negedge clk) begin
    if (rst) in_sel <= 1'b0;
    if (csn_fall) begin n_fall <= n_fall + 1; in_sel <= 1'b1; end
    if (csn_rise) begin n_rise <= n_rise + 1; in_sel <= 1'b0; end
    if (user_out_stb) begin
      got[n_stb]    <= user_out;
      sel_ok[n_stb] <= in_sel;
      n_stb         <= n_stb + 1;
    end
    if (user_in_ack) begin n_ack <= n_ack + 1; ui_acks <= ui_acks + 8'd1; end
  end

  // Scoreboard, owned by the main initial block.
  int         n_cmp = 0, n_bad = 0;
  int         exp_stb = 0, exp_ack = 0, exp_fall = 0, exp_rise = 0, rd = 0;
  logic [7:0] exp_rx [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string ph);
    chk({ph, "_user_out"}, user_out, 0);
    chk({ph, "_stb"},      user_out_stb, 0);
    chk({ph, "_ack"},      user_in_ack, 0);
    chk({ph, "_csn"},      csn_state, 1);
    chk({ph, "_rise"},     csn_rise, 0);
    chk({ph, "_fall"},     csn_fall, 0);
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_fall_cnt"}, n_fall, exp_fall);
    chk({ph, "_rise_cnt"}, n_rise, exp_rise);
    chk({ph, "_ack_cnt"},  n_ack,  exp_ack);
    chk({ph, "_stb_cnt"},  n_stb,  exp_stb);
    while (rd < exp_stb) begin
      if (rd < n_stb) begin
        chk({ph, "_rx"},     got[rd], exp_rx[rd]);
        chk({ph, "_in_sel"}, sel_ok[rd], 1);
      end
      rd++;
    end
  endtask

  // Host: mode 0, set MOSI while low, sample MISO just before the rising edge.
  task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      #(SCK_H);
      mi[7-i] = spi_miso;
      spi_clk = 1'b1;
      #(SCK_H);
      spi_clk = 1'b0;
    end
  endtask

  // Full byte: received byte expected once, one ack; ex = byte the consumer offered.
  task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mi, output logic [7:0] ex);
    ex = user_in;
    xfer_bits(mo, 8, mi);
    exp_rx[exp_stb] = mo;
    exp_stb++;
    exp_ack++;
    #(GAP);
  endtask

  task automatic sel();
    spi_cs_n = 1'b0;
    exp_fall++;
    #(GAP);
  endtask

  task automatic desel();
    #(GAP);
    spi_cs_n = 1'b1;
    exp_rise++;
    #(200.0);
  endtask

  initial begin
    logic [7:0] mi, ex, b;
    int nb;

    // Reset state
    #50;
    chk_reset("rst");
    rst = 1'b0;
    #100;

    // Three bytes in one transaction; consumer starts at A5
    ui_base = 8'hA5 - ui_acks;
    #50;
    sel();
    xfer_byte(8'hA5, mi, ex); chk("t1_miso0", mi, 8'hA5);
    xfer_byte(8'hC1, mi, ex); chk("t1_miso1", mi, 8'hA6);
    xfer_byte(8'hC2, mi, ex); chk("t1_miso2", mi, 8'hA7);
    desel();
    check_all("t1");

    // 13 clocks: one byte plus a discarded partial (its bit 0 still consumes user_in)
    sel();
    b = 8'($urandom);
    xfer_byte(b, mi, ex); chk("t2_miso", mi, ex);
    b = 8'($urandom);
    xfer_bits(b, 5, mi);
    exp_ack++;
    desel();
    check_all("t2");

    // Reselect: next byte aligned from bit 0
    sel();
    b = 8'($urandom);
    xfer_byte(b, mi, ex); chk("t3_miso", mi, ex);
    desel();
    check_all("t3");

    // spi_clk activity while deselected is ignored
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      xfer_bits(b, 1, mi);
      if (i % 5 == 4) chk("t4_csn_idle", csn_state, 1);
    end
    #300;
    check_all("t4");

    // rst mid-byte: outputs back to reset values at once
    sel();
    b = 8'($urandom);
    xfer_bits(b, 3, mi);
    exp_ack++;
    #200;
    rst = 1'b1;
    #1;
    chk_reset("t5");
    spi_cs_n = 1'b1;
    #50;
    rst = 1'b0;
    #100;
    check_all("t5");

    // Normal reception after reset release
    sel();
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      xfer_byte(b, mi, ex); chk("t6_miso", mi, ex);
    end
    desel();
    check_all("t6");

    // Four single-byte transactions
    for (int i = 0; i < 4; i++) begin
      sel();
      b = 8'($urandom);
      xfer_byte(b, mi, ex); chk("t7_miso", mi, ex);
      desel();
    end
    check_all("t7");

    // Random multi-byte transactions
    for (int t = 0; t < 6; t++) begin
      ui_base = 8'($urandom) - ui_acks;
      #50;
      sel();
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        xfer_byte(b, mi, ex); chk("t8_miso", mi, ex);
      end
      desel();
    end
    check_all("t8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
